// File: rtl/aes_cone_match_pipe_pkg.sv
// Shared types and elaboration-time helpers for the pipelined AES cone match.
package aes_cone_pkg;

  localparam int unsigned MAX_W = 64;

  // Nodes beyond the live count of a level are held at 1 so that every
  // reduction can AND across the full vector.
  typedef struct packed {
    logic             valid;
    logic             side;
    logic [MAX_W-1:0] nodes;
  } stage_t;

  function automatic int unsigned clog_base(input int unsigned width, input int unsigned group);
    int unsigned lv;
    int unsigned span;
    lv   = 0;
    span = 1;
    for (int i = 0; i < MAX_W; i++) begin
      if (span < width) begin
        span = span * group;
        lv++;
      end
    end
    return lv;
  endfunction

  function automatic int unsigned node_cnt(input int unsigned width, input int unsigned group,
                                           input int unsigned lvl);
    int unsigned n;
    n = width;
    for (int unsigned i = 0; i < lvl; i++) n = (n + group - 1) / group;
    return n;
  endfunction

  localparam int unsigned DEF_WIDTH  = 10;
  localparam int unsigned DEF_GROUP  = 4;
  localparam int unsigned DEF_LEVELS = clog_base(DEF_WIDTH, DEF_GROUP);
  localparam int unsigned DEF_LAT    = DEF_LEVELS + 1;
  localparam int unsigned DEF_N0     = node_cnt(DEF_WIDTH, DEF_GROUP, 0);
  localparam int unsigned DEF_N1     = node_cnt(DEF_WIDTH, DEF_GROUP, 1);

endpackage

// File: rtl/aes_cone_match_pipe_if.sv
// Item, mask-config and result signals of the cone match pipe.
interface aes_cone_match_pipe_if #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             side_a;
  logic             side_b;
  logic             cfg_we;
  logic [WIDTH-1:0] cfg_care;
  logic [WIDTH-1:0] cfg_pol;
  logic             out_valid;
  logic             out_ready;
  logic             out_y;
  logic [CNT_W-1:0] hit_cnt;
  logic             cnt_clr;

  modport master (
    output in_valid, in_vec, side_a, side_b, cfg_we, cfg_care, cfg_pol, out_ready, cnt_clr,
    input  in_ready, out_valid, out_y, hit_cnt
  );

  modport slave (
    input  in_valid, in_vec, side_a, side_b, cfg_we, cfg_care, cfg_pol, out_ready, cnt_clr,
    output in_ready, out_valid, out_y, hit_cnt
  );
endinterface

// File: rtl/aes_and_tree_level.sv
// One registered GROUP-wide AND reduction level; valid and side ride along.
module aes_and_tree_level
  import aes_cone_pkg::*;
#(
  parameter int unsigned GROUP = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  stage_t d,
  output stage_t q
);

  stage_t nxt;

  // Leaves past the end of the vector read as 1, which ties off partial groups.
  always_comb begin
    nxt       = d;
    nxt.nodes = '1;
    for (int o = 0; o < MAX_W; o++) begin
      for (int g = 0; g < GROUP; g++) begin
        if (o * GROUP + g < MAX_W) nxt.nodes[o] = nxt.nodes[o] & d.nodes[o * GROUP + g];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= nxt;
  end

endmodule

// File: rtl/aes_cone_match_pipe.sv
// Pipelined masked AND-OR(-invert) cone match with valid/ready and a hit counter.
module aes_cone_match_pipe
  import aes_cone_pkg::*;
#(
  parameter int unsigned WIDTH   = 10,
  parameter int unsigned GROUP   = 4,
  parameter bit          OUT_INV = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input logic                  clk,
  input logic                  rst,
  aes_cone_match_pipe_if.slave bus
);

  localparam int unsigned LEVELS = clog_base(WIDTH, GROUP);

  logic [WIDTH-1:0] care_r, pol_r;
  logic             en;
  stage_t           s0_d, s0_q;
  stage_t           tree [LEVELS];
  logic             raw, raw_q, out_valid_q, out_y_q;
  logic [CNT_W-1:0] cnt_q;

  // A stalled output freezes the whole pipe, bubbles included.
  assign en           = !out_valid_q | bus.out_ready;
  assign bus.in_ready = en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      care_r <= '1;
      pol_r  <= '0;
    end else if (bus.cfg_we) begin
      care_r <= bus.cfg_care;
      pol_r  <= bus.cfg_pol;
    end
  end

  always_comb begin
    s0_d                    = '0;
    s0_d.valid              = bus.in_valid;
    s0_d.side               = bus.side_a & bus.side_b;
    s0_d.nodes              = '1;
    s0_d.nodes[WIDTH-1:0]   = ~care_r | ~(bus.in_vec ^ pol_r);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     s0_q <= '0;
    else if (en) s0_q <= s0_d;
  end

  assign tree[0] = s0_q;

  for (genvar l = 1; l < LEVELS; l++) begin : g_lvl
    aes_and_tree_level #(
      .GROUP(GROUP)
    ) u_lvl (
      .clk(clk),
      .rst(rst),
      .en (en),
      .d  (tree[l-1]),
      .q  (tree[l])
    );
  end

  assign raw = tree[LEVELS-1].side | (&tree[LEVELS-1].nodes);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_y_q     <= OUT_INV;
      raw_q       <= 1'b0;
    end else if (en) begin
      out_valid_q <= tree[LEVELS-1].valid;
      out_y_q     <= raw ^ OUT_INV;
      raw_q       <= raw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
    end else if (out_valid_q && bus.out_ready && raw_q && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.hit_cnt   = cnt_q;

endmodule

// File: tb/tb_aes_cone_match_pipe.sv
// Directed self-checking bench for aes_cone_match_pipe (default and CNT_W=2 instances).
module tb_aes_cone_match_pipe;
  import aes_cone_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   passed;

  aes_cone_match_pipe_if #(.WIDTH(10), .CNT_W(16)) bus1 ();
  aes_cone_match_pipe_if #(.WIDTH(10), .CNT_W(2))  bus2 ();

  aes_cone_match_pipe #(
    .WIDTH(10), .GROUP(4), .OUT_INV(1'b1), .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  aes_cone_match_pipe #(
    .WIDTH(10), .GROUP(4), .OUT_INV(1'b1), .CNT_W(2)
  ) dut2 (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cfg_write(input logic [9:0] care, input logic [9:0] pol);
    bus1.cfg_we   = 1'b1;
    bus1.cfg_care = care;
    bus1.cfg_pol  = pol;
    @(posedge clk); #1;
    bus1.cfg_we   = 1'b0;
  endtask

  // One-item transaction on bus1; lat counts edges from accept to out_valid.
  task automatic run_item(input logic [9:0] vec, input logic a, input logic b,
                          output logic y, output int lat);
    bus1.in_vec    = vec;
    bus1.side_a    = a;
    bus1.side_b    = b;
    bus1.in_valid  = 1'b1;
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    bus1.cfg_we   = 1'b0;
    lat = 1;
    while (!bus1.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    y = bus1.out_y;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (bus1.out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus1.out_valid); else passed++;
    checks++; if (bus1.out_y !== 1'b1) $display("FAIL reset_y got %b want 1", bus1.out_y); else passed++;
    checks++; if (bus1.hit_cnt !== 16'd0) $display("FAIL reset_cnt got %0d want 0", bus1.hit_cnt); else passed++;
    checks++; if (bus1.in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus1.in_ready); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_match;
    logic y;
    int   lat;
    cfg_write(10'h3FF, 10'h155);
    run_item(10'h155, 1'b0, 1'b0, y, lat);
    checks++; if (lat !== 3) $display("FAIL match_latency got %0d want 3", lat); else passed++;
    checks++; if (y !== 1'b0) $display("FAIL match_y got %b want 0", y); else passed++;
    checks++; if (bus1.hit_cnt !== 16'd1) $display("FAIL match_cnt got %0d want 1", bus1.hit_cnt); else passed++;
  endtask

  task automatic test_side;
    logic y;
    int   lat;
    run_item(10'h154, 1'b1, 1'b1, y, lat);
    checks++; if (y !== 1'b0) $display("FAIL side_both_y got %b want 0", y); else passed++;
    checks++; if (bus1.hit_cnt !== 16'd2) $display("FAIL side_both_cnt got %0d want 2", bus1.hit_cnt); else passed++;
    run_item(10'h154, 1'b1, 1'b0, y, lat);
    checks++; if (y !== 1'b1) $display("FAIL side_one_y got %b want 1", y); else passed++;
    checks++; if (bus1.hit_cnt !== 16'd2) $display("FAIL side_one_cnt got %0d want 2", bus1.hit_cnt); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [9:0] items [8];
    logic       exp_y [8];
    int         sent;
    int         recv;
    logic       held_y;
    logic       exp_rdy;
    items = '{10'h155, 10'h000, 10'h155, 10'h155, 10'h0AA, 10'h155, 10'h3FF, 10'h155};
    exp_y = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    sent   = 0;
    recv   = 0;
    held_y = 1'b0;
    bus1.side_a = 1'b0;
    bus1.side_b = 1'b0;
    for (int c = 0; c < 20; c++) begin
      bus1.out_ready = !(c >= 4 && c <= 6);
      bus1.in_valid  = (sent < 8);
      bus1.in_vec    = (sent < 8) ? items[sent] : 10'h000;
      #1;
      exp_rdy = !(c >= 4 && c <= 6);
      if (c < 16) begin
        checks++;
        if (bus1.in_ready !== exp_rdy)
          $display("FAIL b2b_ready c=%0d got %b want %b", c, bus1.in_ready, exp_rdy);
        else passed++;
      end
      if (bus1.out_valid && bus1.out_ready) begin
        if (recv < 8) begin
          checks++;
          if (bus1.out_y !== exp_y[recv])
            $display("FAIL b2b_y item=%0d got %b want %b", recv, bus1.out_y, exp_y[recv]);
          else passed++;
        end
        recv++;
      end
      if (c == 4) held_y = bus1.out_y;
      if (c == 5 || c == 6) begin
        checks++;
        if (bus1.out_valid !== 1'b1 || bus1.out_y !== held_y)
          $display("FAIL b2b_hold c=%0d got v=%b y=%b want v=1 y=%b", c, bus1.out_valid,
                   bus1.out_y, held_y);
        else passed++;
      end
      if (bus1.in_valid && bus1.in_ready) sent++;
      @(posedge clk); #1;
    end
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    checks++; if (recv !== 8) $display("FAIL b2b_count got %0d want 8", recv); else passed++;
    checks++; if (sent !== 8) $display("FAIL b2b_sent got %0d want 8", sent); else passed++;
    checks++; if (bus1.hit_cnt !== 16'd7) $display("FAIL b2b_cnt got %0d want 7", bus1.hit_cnt); else passed++;
  endtask

  task automatic test_mask_same_cycle;
    logic y;
    int   lat;
    bus1.cfg_we   = 1'b1;
    bus1.cfg_care = 10'h001;
    bus1.cfg_pol  = 10'h001;
    run_item(10'h001, 1'b0, 1'b0, y, lat);
    checks++; if (y !== 1'b1) $display("FAIL mask_old_y got %b want 1", y); else passed++;
    run_item(10'h001, 1'b0, 1'b0, y, lat);
    checks++; if (y !== 1'b0) $display("FAIL mask_new_y got %b want 0", y); else passed++;
    checks++; if (bus1.hit_cnt !== 16'd8) $display("FAIL mask_cnt got %0d want 8", bus1.hit_cnt); else passed++;
  endtask

  task automatic test_care_zero;
    logic y;
    int   lat;
    cfg_write(10'h000, 10'h155);
    run_item(10'h2AA, 1'b0, 1'b0, y, lat);
    checks++; if (y !== 1'b0) $display("FAIL care0_y got %b want 0", y); else passed++;
    checks++; if (bus1.hit_cnt !== 16'd9) $display("FAIL care0_cnt got %0d want 9", bus1.hit_cnt); else passed++;
  endtask

  task automatic test_saturate;
    int n;
    bus2.in_vec   = 10'h000;
    bus2.in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    bus2.in_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    checks++; if (bus2.hit_cnt !== 2'd3) $display("FAIL sat_cnt got %0d want 3", bus2.hit_cnt); else passed++;
    bus2.in_valid = 1'b1;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    n = 1;
    while (!bus2.out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n !== 3) $display("FAIL clr_latency got %0d want 3", n); else passed++;
    bus2.cnt_clr = 1'b1;
    @(posedge clk); #1;
    bus2.cnt_clr = 1'b0;
    checks++; if (bus2.hit_cnt !== 2'd0) $display("FAIL clr_cnt got %0d want 0", bus2.hit_cnt); else passed++;
  endtask

  task automatic test_reset_mid;
    logic y;
    int   lat;
    int   seen;
    cfg_write(10'h001, 10'h001);
    bus1.in_vec   = 10'h001;
    bus1.side_a   = 1'b0;
    bus1.side_b   = 1'b0;
    bus1.in_valid = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    bus1.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (bus1.out_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", bus1.out_valid); else passed++;
    checks++; if (bus1.out_y !== 1'b1) $display("FAIL rstmid_y got %b want 1", bus1.out_y); else passed++;
    checks++; if (bus1.hit_cnt !== 16'd0) $display("FAIL rstmid_cnt got %0d want 0", bus1.hit_cnt); else passed++;
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < DEF_LAT + 1; i++) begin
      if (bus1.out_valid) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) $display("FAIL rstmid_flush got %0d want 0", seen); else passed++;
    // Masks back at care=all ones, pol=0: bit 0 set must now miss.
    run_item(10'h001, 1'b0, 1'b0, y, lat);
    checks++; if (y !== 1'b1) $display("FAIL rstmid_mask_y got %b want 1", y); else passed++;
    run_item(10'h000, 1'b0, 1'b0, y, lat);
    checks++; if (y !== 1'b0) $display("FAIL rstmid_zero_y got %b want 0", y); else passed++;
    checks++; if (bus1.hit_cnt !== 16'd1) $display("FAIL rstmid_cnt2 got %0d want 1", bus1.hit_cnt); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst    = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_vec = '0; bus1.side_a = 1'b0; bus1.side_b = 1'b0;
    bus1.cfg_we = 1'b0; bus1.cfg_care = '0; bus1.cfg_pol = '0;
    bus1.out_ready = 1'b1; bus1.cnt_clr = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_vec = '0; bus2.side_a = 1'b0; bus2.side_b = 1'b0;
    bus2.cfg_we = 1'b0; bus2.cfg_care = '0; bus2.cfg_pol = '0;
    bus2.out_ready = 1'b1; bus2.cnt_clr = 1'b0;
    test_reset;
    test_saturate;
    test_match;
    test_side;
    test_back_to_back;
    test_mask_same_cycle;
    test_care_zero;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
